// File: rtl/arb_mux_n_to_1.sv
// N-to-1 valid/ready stream mux with one registered output stage.
// The channel is picked either by sel (mode=0) or by a round-robin pointer (mode=1).
module arb_mux_n_to_1 #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int LOGN = $clog2(N)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              mode,
    input  logic [LOGN-1:0]   sel,
    input  logic [N*W-1:0]    inData,
    input  logic [N-1:0]      inValid,
    output logic [N-1:0]      inReady,
    output logic [W-1:0]      outData,
    output logic              outValid,
    input  logic              outReady,
    output logic [LOGN-1:0]   outChan
);

    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [LOGN-1:0] out_chan_q, out_chan_d;
    logic [LOGN-1:0] ptr_q, ptr_d;

    logic            load;
    logic            grant;
    logic            found;
    logic [LOGN-1:0] cand;
    logic            rr_found;
    logic [LOGN-1:0] rr_cand;
    logic [LOGN:0]   rr_sum;
    logic [LOGN-1:0] rr_idx;
    logic [N-1:0]    fixed_hit;
    logic [W-1:0]    chan_data [N];

    assign load  = !out_valid_q || outReady;
    // Gating with rstN keeps every inReady low for as long as reset is held.
    assign grant = rstN && load && found;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign chan_data[gi] = inData[gi*W +: W];
            assign fixed_hit[gi] = inValid[gi] && (sel == LOGN'(gi));
            assign inReady[gi]   = grant && (cand == LOGN'(gi));
        end
    endgenerate

    // Scan ptr, ptr+1, ... wrapping at N; the first valid channel wins.
    always_comb begin
        rr_found = 1'b0;
        rr_cand  = '0;
        rr_sum   = '0;
        rr_idx   = '0;
        for (int k = 0; k < N; k++) begin
            rr_sum = {1'b0, ptr_q} + (LOGN+1)'(k);
            if (rr_sum >= (LOGN+1)'(N)) begin
                rr_sum = rr_sum - (LOGN+1)'(N);
            end
            rr_idx = rr_sum[LOGN-1:0];
            if (!rr_found && inValid[rr_idx]) begin
                rr_found = 1'b1;
                rr_cand  = rr_idx;
            end
        end
    end

    // An out-of-range sel matches no fixed_hit bit, so it never grants.
    assign found = mode ? rr_found : (|fixed_hit);
    assign cand  = mode ? rr_cand  : sel;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (found) begin
                out_data_d  = chan_data[cand];
                out_chan_d  = cand;
                out_valid_d = 1'b1;
                if (mode) begin
                    ptr_d = (cand == LOGN'(N-1)) ? '0 : cand + LOGN'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign outData  = out_data_q;
    assign outValid = out_valid_q;
    assign outChan  = out_chan_q;

endmodule

// File: tb/tb_arb_mux_n_to_1.sv
// Randomised and directed checks of arb_mux_n_to_1 against a transaction-level model,
// with extra instances for N=6 (sel out of range) and N=3 (non-power-of-two wrap).
module tb_arb_mux_n_to_1;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_chan;

    logic        mode6;
    logic [2:0]  sel6;
    logic [47:0] data6;
    logic [5:0]  valid6;
    logic [5:0]  ready6;
    logic [7:0]  out_data6;
    logic        out_valid6;
    logic        out_ready6;
    logic [2:0]  out_chan6;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] data3;
    logic [2:0]  valid3;
    logic [2:0]  ready3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_chan3;

    arb_mux_n_to_1 #(.N(N), .W(W)) u_dut (
        .clk(clk), .rstN(rst_n), .mode(mode), .sel(sel),
        .inData(in_data), .inValid(in_valid), .inReady(in_ready),
        .outData(out_data), .outValid(out_valid), .outReady(out_ready), .outChan(out_chan)
    );

    arb_mux_n_to_1 #(.N(6), .W(8)) u_dut6 (
        .clk(clk), .rstN(rst_n), .mode(mode6), .sel(sel6),
        .inData(data6), .inValid(valid6), .inReady(ready6),
        .outData(out_data6), .outValid(out_valid6), .outReady(out_ready6), .outChan(out_chan6)
    );

    arb_mux_n_to_1 #(.N(3), .W(8)) u_dut3 (
        .clk(clk), .rstN(rst_n), .mode(mode3), .sel(sel3),
        .inData(data3), .inValid(valid3), .inReady(ready3),
        .outData(out_data3), .outValid(out_valid3), .outReady(out_ready3), .outChan(out_chan3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model of the N=4 instance.
    bit         m_valid;
    int         m_chan;
    int         m_ptr;
    logic [7:0] m_data;

    function automatic int ref_cand();
        if (!mode) begin
            if (in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] ref_ready();
        int c;
        logic [3:0] one;
        one = 4'b0001;
        c = ref_cand();
        if (m_valid && !out_ready) return 4'b0000;
        if (c < 0) return 4'b0000;
        return one << c;
    endfunction

    task automatic ref_clock();
        int c;
        c = ref_cand();
        if (!m_valid || out_ready) begin
            if (c >= 0) begin
                m_valid = 1'b1;
                m_chan  = c;
                m_data  = in_data[c*8 +: 8];
                if (mode) m_ptr = (c + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic ref_reset();
        m_valid = 1'b0;
        m_chan  = 0;
        m_ptr   = 0;
        m_data  = 8'h00;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            $display("xfer t=%0t chan=%0d data=%02h", $time, out_chan, out_data);
    end

    task automatic test_reset();
        logic [3:0] exp_r;
        mode = 1'b1; sel = 2'd0; in_valid = 4'hF; in_data = 32'h0; out_ready = 1'b1;
        rst_n = 1'b0;
        ref_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_chan, out_data} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b c=%0d d=%02h, want all zero", out_valid, out_chan, out_data);
        end
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0000", in_ready);
        end
        #2 rst_n = 1'b1;
        #1;
        exp_r = ref_ready();
        n_checks++;
        if (in_ready !== exp_r) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want %b", in_ready, exp_r);
        end
    endtask

    task automatic test_rr_all();
        logic [3:0] exp_r;
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = $urandom;
            #1;
            exp_r = ref_ready();
            n_checks++;
            if (in_ready !== exp_r) begin
                n_fail++;
                $display("FAIL rr_all_ready[%0d]: got %b want %b", k, in_ready, exp_r);
            end
            @(posedge clk);
            ref_clock();
            #1;
            n_checks++;
            if ({out_valid, out_chan, out_data} !== {m_valid, 2'(m_chan), m_data}) begin
                n_fail++;
                $display("FAIL rr_all_out[%0d]: got v=%b c=%0d d=%02h want v=%b c=%0d d=%02h",
                         k, out_valid, out_chan, out_data, m_valid, m_chan, m_data);
            end
            n_checks++;
            if (out_chan !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL rr_all_seq[%0d]: got chan %0d want %0d", k, out_chan, k % 4);
            end
        end
    endtask

    task automatic test_rr_sparse();
        logic [3:0] exp_r;
        int exp_chan [3] = '{3, 0, 3};
        mode = 1'b1; out_ready = 1'b1;
        in_valid = 4'b0001; in_data = $urandom;
        #1;
        @(posedge clk);
        ref_clock();
        #1;
        in_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            in_data = $urandom;
            #1;
            exp_r = ref_ready();
            n_checks++;
            if (in_ready !== exp_r || in_ready[2:1] !== 2'b00) begin
                n_fail++;
                $display("FAIL rr_sparse_ready[%0d]: got %b want %b", k, in_ready, exp_r);
            end
            @(posedge clk);
            ref_clock();
            #1;
            n_checks++;
            if ({out_valid, out_chan, out_data} !== {m_valid, 2'(m_chan), m_data}
                || out_chan !== 2'(exp_chan[k])) begin
                n_fail++;
                $display("FAIL rr_sparse_out[%0d]: got v=%b c=%0d d=%02h want v=1 c=%0d d=%02h",
                         k, out_valid, out_chan, out_data, exp_chan[k], m_data);
            end
        end
    endtask

    task automatic test_fixed();
        logic [3:0] exp_r;
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = 32'h44A5_2211; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL fixed_ready: got %b want 0100", in_ready);
        end
        @(posedge clk);
        ref_clock();
        #1;
        n_checks++;
        if ({out_valid, out_chan, out_data} !== {1'b1, 2'd2, 8'hA5}) begin
            n_fail++;
            $display("FAIL fixed_out: got v=%b c=%0d d=%02h want v=1 c=2 d=a5", out_valid, out_chan, out_data);
        end
        for (int k = 0; k < 12; k++) begin
            sel = 2'($urandom_range(0, 3));
            in_valid = 4'($urandom);
            in_data = $urandom;
            #1;
            exp_r = ref_ready();
            n_checks++;
            if (in_ready !== exp_r) begin
                n_fail++;
                $display("FAIL fixed_rand_ready[%0d]: got %b want %b", k, in_ready, exp_r);
            end
            @(posedge clk);
            ref_clock();
            #1;
            n_checks++;
            if ({out_valid, out_chan, out_data} !== {m_valid, 2'(m_chan), m_data}) begin
                n_fail++;
                $display("FAIL fixed_rand_out[%0d]: got v=%b c=%0d d=%02h want v=%b c=%0d d=%02h",
                         k, out_valid, out_chan, out_data, m_valid, m_chan, m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        mode = 1'b0; sel = 2'd1; in_valid = 4'hF; in_data = $urandom; out_ready = 1'b0;
        #1;
        @(posedge clk);
        ref_clock();
        #1;
        held = out_data;
        n_checks++;
        if ({out_valid, out_chan, out_data} !== {m_valid, 2'(m_chan), m_data}) begin
            n_fail++;
            $display("FAIL bp_load: got v=%b c=%0d d=%02h want v=%b c=%0d d=%02h",
                     out_valid, out_chan, out_data, m_valid, m_chan, m_data);
        end
        for (int k = 0; k < 3; k++) begin
            in_data = $urandom;
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", k, in_ready);
            end
            @(posedge clk);
            ref_clock();
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== m_data || out_chan !== 2'd1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b c=%0d d=%02h want v=1 c=1 d=%02h",
                         k, out_valid, out_chan, out_data, held);
            end
        end
        out_ready = 1'b1; sel = 2'd3; in_data = $urandom;
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1000", in_ready);
        end
        @(posedge clk);
        ref_clock();
        #1;
        n_checks++;
        if ({out_valid, out_chan, out_data} !== {1'b1, 2'd3, m_data}) begin
            n_fail++;
            $display("FAIL bp_release_out: got v=%b c=%0d d=%02h want v=1 c=3 d=%02h",
                     out_valid, out_chan, out_data, m_data);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_r;
        int bad_r = 0;
        int bad_o = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel = 2'($urandom);
            in_valid = 4'($urandom);
            in_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_r = ref_ready();
            n_checks++;
            if (in_ready !== exp_r) begin
                n_fail++;
                bad_r++;
                if (bad_r <= 5)
                    $display("FAIL random_ready[%0d]: got %b want %b", k, in_ready, exp_r);
            end
            @(posedge clk);
            ref_clock();
            #1;
            n_checks++;
            if ({out_valid, out_chan, out_data} !== {m_valid, 2'(m_chan), m_data}) begin
                n_fail++;
                bad_o++;
                if (bad_o <= 5)
                    $display("FAIL random_out[%0d]: got v=%b c=%0d d=%02h want v=%b c=%0d d=%02h",
                             k, out_valid, out_chan, out_data, m_valid, m_chan, m_data);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        mode = 1'b1; in_valid = 4'hF; in_data = $urandom; out_ready = 1'b0;
        #1;
        @(posedge clk);
        ref_clock();
        #3;
        rst_n = 1'b0;
        ref_reset();
        #1;
        n_checks++;
        if ({out_valid, out_chan, out_data} !== 11'b0 || in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_async: got v=%b c=%0d d=%02h r=%b want all zero",
                     out_valid, out_chan, out_data, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_hold: got r=%b v=%b want r=0000 v=0", in_ready, out_valid);
        end
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_first_ready: got %b want 0001", in_ready);
        end
        @(posedge clk);
        ref_clock();
        #1;
        n_checks++;
        if ({out_valid, out_chan, out_data} !== {1'b1, 2'd0, in_data[7:0]}) begin
            n_fail++;
            $display("FAIL midreset_first_grant: got v=%b c=%0d d=%02h want v=1 c=0 d=%02h",
                     out_valid, out_chan, out_data, in_data[7:0]);
        end
    endtask

    task automatic test_sel_range();
        mode6 = 1'b0; out_ready6 = 1'b1; data6 = 48'hF5E4_D3C2_B1A0;
        sel6 = 3'd5; valid6 = 6'b011111;
        #1;
        n_checks++;
        if (ready6 !== 6'b0) begin
            n_fail++;
            $display("FAIL sel5_invalid_ready: got %b want 000000", ready6);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid6 !== 1'b0) begin
            n_fail++;
            $display("FAIL sel5_invalid_out: got v=%b want 0", out_valid6);
        end
        for (int s = 6; s < 8; s++) begin
            sel6 = 3'(s); valid6 = 6'h3F;
            #1;
            n_checks++;
            if (ready6 !== 6'b0) begin
                n_fail++;
                $display("FAIL sel%0d_range_ready: got %b want 000000", s, ready6);
            end
        end
        sel6 = 3'd5;
        #1;
        n_checks++;
        if (ready6 !== 6'b100000) begin
            n_fail++;
            $display("FAIL sel5_ready: got %b want 100000", ready6);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid6, out_chan6, out_data6} !== {1'b1, 3'd5, 8'hF5}) begin
            n_fail++;
            $display("FAIL sel5_out: got v=%b c=%0d d=%02h want v=1 c=5 d=f5", out_valid6, out_chan6, out_data6);
        end
        sel6 = 3'd7;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid6, out_chan6, out_data6} !== {1'b0, 3'd5, 8'hF5}) begin
            n_fail++;
            $display("FAIL sel7_drain: got v=%b c=%0d d=%02h want v=0 c=5 d=f5", out_valid6, out_chan6, out_data6);
        end
    endtask

    task automatic test_non_pow2();
        logic [2:0] one;
        logic [7:0] exp_d;
        one = 3'b001;
        mode3 = 1'b1; valid3 = 3'b111; out_ready3 = 1'b1; data3 = 24'h33_2211;
        for (int k = 0; k < 7; k++) begin
            #1;
            n_checks++;
            if (ready3 !== (one << (k % 3))) begin
                n_fail++;
                $display("FAIL np2_ready[%0d]: got %b want %b", k, ready3, one << (k % 3));
            end
            @(posedge clk);
            #1;
            exp_d = 8'((k % 3 + 1) * 8'h11);
            n_checks++;
            if ({out_valid3, out_chan3, out_data3} !== {1'b1, 2'(k % 3), exp_d}) begin
                n_fail++;
                $display("FAIL np2_out[%0d]: got v=%b c=%0d d=%02h want v=1 c=%0d d=%02h",
                         k, out_valid3, out_chan3, out_data3, k % 3, exp_d);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
        mode6 = 1'b0; sel6 = '0; data6 = '0; valid6 = '0; out_ready6 = 1'b0;
        mode3 = 1'b0; sel3 = '0; data3 = '0; valid3 = '0; out_ready3 = 1'b0;
        ref_reset();

        test_reset();
        test_rr_all();
        test_rr_sparse();
        test_fixed();
        test_backpressure();
        test_random();
        test_reset_mid_stream();
        test_sel_range();
        test_non_pow2();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
